cmac_tx_axis_arbiter: RTL

- Packet-granular, two-input round-robin arbiter that shares the single CMAC 512-bit TX AXI-Stream port between two requesters.
- Source 0 is the ERNIC TX stream; source 1 is the packet-generator / test stream.
- Sits between the two sources and the CMAC tx_axis_* inputs, in the txusrclk2 domain.
- Also gates new packets on link enable, aborts packets whose source stalls mid-frame, and keeps per-source statistics.

---
 rtl/cmac_tx_axis_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cmac_tx_axis_arbiter.sv
// rtl/cmac_tx_axis_arbiter.sv - packet-granular two-source round-robin arbiter for the CMAC TX stream
//
// Purpose: shares the single CMAC TX AXI-Stream port between source 0 (ERNIC)
// and source 1 (packet generator / test). Grants whole packets, alternates on
// contention, gates new grants on tx_enable, aborts packets whose source starves
// mid-frame (error beat with tuser=1, then drains the rest), keeps counters.
//
// Ports:
//   aclk, aresetn              TX user clock, asynchronous active-low reset
//   tx_enable                  new grants are issued only while high
//   s0_axis_*                  source 0 stream (tdata/tkeep/tvalid/tlast in, tready out)
//   s1_axis_*                  source 1 stream (tdata/tkeep/tvalid/tlast in, tready out)
//   m_axis_*                   to CMAC tx_axis_* (tdata/tkeep/tvalid/tlast/tuser out, tready in)
//   grant                      one-hot owner, 00 when idle
//   pkt_cnt0, pkt_cnt1         good packets forwarded per source (wrapping)
//   abort_cnt                  aborted packets, both sources (saturating)
//   busy                       high whenever not idle

module cmac_tx_axis_arbiter #(
  parameter int DATA_W        = 512,
  parameter int KEEP_W        = 64,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              tx_enable,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic              m_axis_tready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [7:0]        abort_cnt,
  output logic              busy
);

  // Counter only has to reach STALL_TIMEOUT-1; one spare value keeps the width sane for tiny timeouts.
  localparam int              SW         = $clog2(STALL_TIMEOUT + 2);
  localparam bit              STALL_EN   = (STALL_TIMEOUT != 0);
  localparam logic [SW-1:0]   STALL_LAST = SW'((STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    ABORT  = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic          owner;       // source that owns the current packet (held through ABORT/DRAIN)
  logic          last_grant;  // last source granted; resets to 1 so source 0 wins first
  logic [SW-1:0] stall_cnt;

  logic              src_valid;
  logic              src_last;
  logic [DATA_W-1:0] src_data;
  logic [KEEP_W-1:0] src_keep;
  logic              in_grant;
  logic              arb_fire;
  logic              pick;
  logic              stall_hit;
  logic              pkt_done;

  assign src_valid = owner ? s1_axis_tvalid : s0_axis_tvalid;
  assign src_last  = owner ? s1_axis_tlast  : s0_axis_tlast;
  assign src_data  = owner ? s1_axis_tdata  : s0_axis_tdata;
  assign src_keep  = owner ? s1_axis_tkeep  : s0_axis_tkeep;

  assign in_grant  = (state == GRANT0) || (state == GRANT1);
  assign arb_fire  = (state == IDLE) && tx_enable && (s0_axis_tvalid || s1_axis_tvalid);
  // On contention take the source that did not go last; otherwise whoever asks.
  assign pick      = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_grant : s1_axis_tvalid;
  // A valid beat clears the count, so a tlast beat can never collide with a timeout.
  assign stall_hit = STALL_EN && !src_valid && (stall_cnt == STALL_LAST);
  assign pkt_done  = in_grant && src_valid && m_axis_tready && src_last;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;

    case (state)
      IDLE: begin
        if (arb_fire) state_nxt = pick ? GRANT1 : GRANT0;
      end
      GRANT0, GRANT1: begin
        m_axis_tdata  = src_data;
        m_axis_tkeep  = src_keep;
        m_axis_tvalid = src_valid;
        m_axis_tlast  = src_last;
        grant         = owner ? 2'b10 : 2'b01;
        if (owner) s1_axis_tready = m_axis_tready;
        else       s0_axis_tready = m_axis_tready;
        if (pkt_done)       state_nxt = IDLE;
        else if (stall_hit) state_nxt = ABORT;
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = '1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        grant         = owner ? 2'b10 : 2'b01;
        if (m_axis_tready) state_nxt = DRAIN;
      end
      DRAIN: begin
        grant = owner ? 2'b10 : 2'b01;
        if (owner) s1_axis_tready = 1'b1;
        else       s0_axis_tready = 1'b1;
        if (src_valid && src_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      stall_cnt  <= '0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
      abort_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (arb_fire) begin
        owner      <= pick;
        last_grant <= pick;
      end

      if (!in_grant)      stall_cnt <= '0;
      else if (src_valid) stall_cnt <= '0;
      else                stall_cnt <= stall_cnt + 1'b1;

      if (pkt_done) begin
        if (owner) pkt_cnt1 <= pkt_cnt1 + 1'b1;
        else       pkt_cnt0 <= pkt_cnt0 + 1'b1;
      end

      if ((state == ABORT) && m_axis_tready && (abort_cnt != 8'hFF))
        abort_cnt <= abort_cnt + 8'd1;
    end
  end

endmodule
